// File: rtl/idct8_chen_ts.sv
// 8-point 1-D inverse DCT (Chen), eight shared LUT multipliers over four phases.
// Optional macro IDCT8_PIXEL_CLAMP_EN saturates outputs to the level-shifted 8-bit pixel range.

(* use_dsp = "no" *)
module lut_multiplier #(
  parameter int A_W  = 32,
  parameter int B_W  = 16,
  parameter int FRAC = 15
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [A_W-1:0] p
);
  logic signed [A_W+B_W-1:0] full;

  assign full = a * b;
  assign p    = A_W'(full >>> FRAC);
endmodule

module idct8_chen_ts #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 15,
  parameter int CONST_W = 16,
  parameter int NUM_MUL = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in0,
  input  logic [IN_W-1:0] in1,
  input  logic [IN_W-1:0] in2,
  input  logic [IN_W-1:0] in3,
  input  logic [IN_W-1:0] in4,
  input  logic [IN_W-1:0] in5,
  input  logic [IN_W-1:0] in6,
  input  logic [IN_W-1:0] in7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] out0,
  output logic [IN_W-1:0] out1,
  output logic [IN_W-1:0] out2,
  output logic [IN_W-1:0] out3,
  output logic [IN_W-1:0] out4,
  output logic [IN_W-1:0] out5,
  output logic [IN_W-1:0] out6,
  output logic [IN_W-1:0] out7
);
  // Handshake: a row moves on any rising edge where valid && ready; in_ready is
  // high only in S_IDLE and out_valid only in S_WAIT, so they are never both high.

  localparam int SH = 16 - CONST_W;
  localparam logic signed [CONST_W-1:0] C1 = CONST_W'(32138 >>> SH);
  localparam logic signed [CONST_W-1:0] C2 = CONST_W'(30274 >>> SH);
  localparam logic signed [CONST_W-1:0] C3 = CONST_W'(27246 >>> SH);
  localparam logic signed [CONST_W-1:0] C4 = CONST_W'(23170 >>> SH);
  localparam logic signed [CONST_W-1:0] C6 = CONST_W'(12540 >>> SH);
  localparam logic signed [CONST_W-1:0] S1 = CONST_W'(6393 >>> SH);
  localparam logic signed [CONST_W-1:0] S3 = CONST_W'(18205 >>> SH);
  localparam logic signed [CONST_W-1:0] K0 = CONST_W'(11585 >>> SH);
  localparam logic signed [CONST_W-1:0] KH = CONST_W'(16384 >>> SH);

`ifdef IDCT8_PIXEL_CLAMP_EN
  localparam logic signed [IN_W-1:0] PIX_MAX = IN_W'(127 << FRAC);
  localparam logic signed [IN_W-1:0] PIX_MIN = IN_W'(-(128 << FRAC));

  function automatic logic signed [IN_W-1:0] pix(input logic signed [IN_W-1:0] v);
    if (v > PIX_MAX) return PIX_MAX;
    else if (v < PIX_MIN) return PIX_MIN;
    else return v;
  endfunction
`else
  function automatic logic signed [IN_W-1:0] pix(input logic signed [IN_W-1:0] v);
    return v;
  endfunction
`endif

  typedef enum logic [2:0] {S_IDLE, P0, P1, P2, P3, S_WAIT} state_t;
  state_t state, state_nxt;

  logic signed [IN_W-1:0]    din  [8];
  logic signed [IN_W-1:0]    u    [8];
  logic signed [IN_W-1:0]    res  [8];
  logic signed [IN_W-1:0]    outr [8];
  logic signed [IN_W-1:0]    g0, g1, h0, h1;
  logic signed [IN_W-1:0]    o0, o1, o2, o3;
  logic signed [IN_W-1:0]    o0f, o1f, o2f, o3f;
  logic signed [IN_W-1:0]    e0, e1, e2, e3;
  logic signed [IN_W-1:0]    ma [NUM_MUL];
  logic signed [CONST_W-1:0] mb [NUM_MUL];
  logic signed [IN_W-1:0]    mp [NUM_MUL];

  for (genvar i = 0; i < NUM_MUL; i++) begin : g_mul
    lut_multiplier #(.A_W(IN_W), .B_W(CONST_W), .FRAC(FRAC)) u_mul (
      .a(ma[i]),
      .b(mb[i]),
      .p(mp[i])
    );
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_WAIT);
  assign out0 = outr[0];
  assign out1 = outr[1];
  assign out2 = outr[2];
  assign out3 = outr[3];
  assign out4 = outr[4];
  assign out5 = outr[5];
  assign out6 = outr[6];
  assign out7 = outr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nxt = P0;
      P0:     state_nxt = P1;
      P1:     state_nxt = P2;
      P2:     state_nxt = P3;
      P3:     state_nxt = S_WAIT;
      S_WAIT: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplier schedule; idle slots see zero operands.
  always_comb begin
    for (int i = 0; i < NUM_MUL; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    unique case (state)
      P0: begin
        for (int i = 0; i < NUM_MUL; i++) begin
          ma[i] = din[i];
          mb[i] = (i == 0) ? K0 : KH;
        end
      end
      P1: begin
        ma[0] = u[4]; mb[0] = C4;
        ma[1] = u[2]; mb[1] = C2;
        ma[2] = u[6]; mb[2] = C6;
        ma[3] = u[2]; mb[3] = C6;
        ma[4] = u[6]; mb[4] = C2;
        ma[5] = u[1]; mb[5] = C1;
        ma[6] = u[1]; mb[6] = C3;
        ma[7] = u[1]; mb[7] = S3;
      end
      P2: begin
        ma[0] = u[3]; mb[0] = C3;
        ma[1] = u[5]; mb[1] = S3;
        ma[2] = u[3]; mb[2] = S1;
        ma[3] = u[5]; mb[3] = C1;
        ma[4] = u[3]; mb[4] = C1;
        ma[5] = u[5]; mb[5] = S1;
        ma[6] = u[3]; mb[6] = S3;
        ma[7] = u[5]; mb[7] = C3;
      end
      P3: begin
        ma[0] = u[1]; mb[0] = S1;
        ma[1] = u[7]; mb[1] = S1;
        ma[2] = u[7]; mb[2] = S3;
        ma[3] = u[7]; mb[3] = C3;
        ma[4] = u[7]; mb[4] = C1;
      end
      default: ;
    endcase
  end

  // Final odd terms and butterflies, consumed only in P3.
  always_comb begin
    o0f = o0 + mp[1];
    o1f = o1 - mp[2];
    o2f = o2 + mp[3];
    o3f = o3 + mp[0] - mp[4];
    e0  = g0 + h0;
    e1  = g1 + h1;
    e2  = g1 - h1;
    e3  = g0 - h0;
    res[0] = e0 + o0f;
    res[1] = e1 + o1f;
    res[2] = e2 + o2f;
    res[3] = e3 + o3f;
    res[4] = e3 - o3f;
    res[5] = e2 - o2f;
    res[6] = e1 - o1f;
    res[7] = e0 - o0f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        din[i]  <= '0;
        u[i]    <= '0;
        outr[i] <= '0;
      end
      g0 <= '0; g1 <= '0; h0 <= '0; h1 <= '0;
      o0 <= '0; o1 <= '0; o2 <= '0; o3 <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          din[0] <= in0; din[1] <= in1; din[2] <= in2; din[3] <= in3;
          din[4] <= in4; din[5] <= in5; din[6] <= in6; din[7] <= in7;
        end
        P0: for (int i = 0; i < 8; i++) u[i] <= mp[i];
        P1: begin
          g0 <= u[0] + mp[0];
          g1 <= u[0] - mp[0];
          h0 <= mp[1] + mp[2];
          h1 <= mp[3] - mp[4];
          o0 <= mp[5];
          o1 <= mp[6];
          o2 <= mp[7];
          o3 <= '0;
        end
        P2: begin
          o0 <= o0 + mp[0] + mp[1];
          o1 <= o1 - mp[2] - mp[3];
          o2 <= o2 - mp[4] + mp[5];
          o3 <= o3 - mp[6] + mp[7];
        end
        P3: for (int i = 0; i < 8; i++) outr[i] <= pix(res[i]);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_idct8_chen_ts.sv
// Bench for idct8_chen_ts: directed rows plus random rows checked against an arithmetic IDCT model.
module tb_idct8_chen_ts;
  localparam int W  = 32;
  localparam int RW = 8 * W;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [RW-1:0] in_row, out_row, held_row;
  logic [W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit held = 0;

  always #5 clk = ~clk;

  assign in0 = in_row[0*W +: W];
  assign in1 = in_row[1*W +: W];
  assign in2 = in_row[2*W +: W];
  assign in3 = in_row[3*W +: W];
  assign in4 = in_row[4*W +: W];
  assign in5 = in_row[5*W +: W];
  assign in6 = in_row[6*W +: W];
  assign in7 = in_row[7*W +: W];
  assign out_row = {out7, out6, out5, out4, out3, out2, out1, out0};

  idct8_chen_ts dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7)
  );

  // Reference: fixed-point product is floor(a*c / 2^15), sums wrap at 32 bits.
  function automatic int mul(input int a, input int c);
    longint p;
    p = longint'(a) * longint'(c);
    return int'(p >>> 15);
  endfunction

  function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] xin);
    int x[8], u[8], e[4], o[4], y[8];
    int g0, g1, h0, h1;
    logic [RW-1:0] r;
    for (int k = 0; k < 8; k++) x[k] = int'(xin[k*W +: W]);
    u[0] = mul(x[0], 11585);
    for (int k = 1; k < 8; k++) u[k] = mul(x[k], 16384);
    g0 = u[0] + mul(u[4], 23170);
    g1 = u[0] - mul(u[4], 23170);
    h0 = mul(u[2], 30274) + mul(u[6], 12540);
    h1 = mul(u[2], 12540) - mul(u[6], 30274);
    e[0] = g0 + h0; e[1] = g1 + h1; e[2] = g1 - h1; e[3] = g0 - h0;
    o[0] = mul(u[1], 32138) + mul(u[3], 27246) + mul(u[5], 18205) + mul(u[7], 6393);
    o[1] = mul(u[1], 27246) - mul(u[3], 6393) - mul(u[5], 32138) - mul(u[7], 18205);
    o[2] = mul(u[1], 18205) - mul(u[3], 32138) + mul(u[5], 6393) + mul(u[7], 27246);
    o[3] = mul(u[1], 6393) - mul(u[3], 18205) + mul(u[5], 27246) - mul(u[7], 32138);
    for (int n = 0; n < 4; n++) begin
      y[n]     = e[n] + o[n];
      y[7 - n] = e[n] - o[n];
    end
    for (int k = 0; k < 8; k++) begin
`ifdef IDCT8_PIXEL_CLAMP_EN
      if (y[k] > 4161536) y[k] = 4161536;
      else if (y[k] < -4194304) y[k] = -4194304;
`endif
      r[k*W +: W] = y[k];
    end
    return r;
  endfunction

  function automatic int rand_word();
    case ($urandom_range(0, 2))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 1048576)) - 524288;
      default: return 0;
    endcase
  endfunction

  task automatic check_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: exclusivity, hold stability under backpressure, and row scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (out_valid) begin
      check1("valid_ready_exclusive", int'(in_ready), 0);
      if (held) check_row("hold_stable", out_row, held_row);
      if (out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_row: got %h expected none", out_row);
        end else begin
          logic [RW-1:0] e;
          e = exp_q.pop_front();
          total--;
          check_row("row", out_row, e);
        end
        held = 0;
      end else begin
        held = 1;
        held_row = out_row;
      end
    end else begin
      held = 0;
    end
  end

  task automatic send_row(input logic [RW-1:0] r, input bit push, output int waited);
    bit acc;
    in_row = r;
    in_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 50);
    in_valid = 1'b0;
    if (!acc) check1("accept_timeout", 0, 1);
    else if (push) exp_q.push_back(ref_row(r));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check1("valid_timeout", 0, 1);
  endtask

  task automatic finish_row(input int stall);
    wait_valid();
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [RW-1:0] one_hot(input int idx, input int val);
    logic [RW-1:0] r = '0;
    r[idx*W +: W] = val;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [RW-1:0] r;
    int clamp_exp;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_row = '0;
    #22;
    check1("reset_in_ready", int'(in_ready), 1);
    check1("reset_out_valid", int'(out_valid), 0);
    check_row("reset_outputs", out_row, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DC row with latency check.
    out_ready = 1'b1;
    send_row(one_hot(0, 262144), 1, w);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check1($sformatf("latency_edge%0d", k), int'(out_valid), (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 8; k++) check1($sformatf("dc_out%0d", k), int'(out_row[k*W +: W]), 92680);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    send_row(one_hot(4, 65536), 1, w);
    finish_row(0);
    send_row(one_hot(1, 65536), 1, w);
    finish_row(1);

    // Backpressure with a pending new row on the input.
    send_row(one_hot(2, 65536), 1, w);
    wait_valid();
    in_row = one_hot(6, 131072);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check1("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_row(one_hot(6, 131072), 1, w);
    out_ready = 1'b0;
    check1("bp_accept_edges", w, 2);
    finish_row(2);

    // Reset during P2.
    r = '0;
    for (int k = 0; k < 8; k++) r[k*W +: W] = 1000 * (k + 1);
    send_row(r, 0, w);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check1("midrst_out_valid", int'(out_valid), 0);
    check1("midrst_in_ready", int'(in_ready), 1);
    check_row("midrst_outputs", out_row, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_row(r, 1, w);
    finish_row(0);

    // Large DC row exercising the clamp.
`ifdef IDCT8_PIXEL_CLAMP_EN
    clamp_exp = 4161536;
`else
    clamp_exp = 11585000;
`endif
    send_row(one_hot(0, 32768000), 1, w);
    wait_valid();
    for (int k = 0; k < 8; k++) check1($sformatf("clamp_out%0d", k), int'(out_row[k*W +: W]), clamp_exp);
    finish_row(0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) r[k*W +: W] = rand_word();
      send_row(r, 1, w);
      finish_row($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    check1("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idct8_chen_ts.md
Name: idct8_chen_ts

Overview:
- 8-point 1-D inverse DCT (Chen factorisation), the decode-side counterpart of the forward row/column DCT in the compression pipeline.
- Takes one row of 8 fixed-point coefficients and returns 8 spatial samples.
- Uses NUM_MUL time-shared LUT multipliers (lut_multiplier, use_dsp="no") over 4 phases.
- Valid/ready handshake identical to the forward DCT, so the two blocks chain or swap directly.

Parameters:
- IN_W, 32, data width of coefficients and samples (signed, Q(IN_W-FRAC).FRAC).
- FRAC, 15, fractional bits of data and constants; multiplier result = (a*b) >>> FRAC (arithmetic shift, truncating).
- CONST_W, 16, constant width; constants are Q15 values >> (16-CONST_W).
- NUM_MUL, 8, shared multiplier count. The schedule below is fixed for 8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  coefficient row valid
- in_ready  out  1  block can accept a row
- in0..in7  in  IN_W each  signed coefficients X0..X7
- out_valid  out  1  sample row valid
- out_ready  in  1  sink accepts the row
- out0..out7  out  IN_W each  signed samples x0..x7

Behaviour:
- Constants (Q15):
  - C1=32138, C2=30274, C3=27246, C4=23170, C6=12540.
  - S1=6393, S3=18205.
  - K0=11585 (1/(2*sqrt2)), K=16384 (0.5).
- Math:
  - Prescale: u0=X0*K0; uk=Xk*K for k=1..7.
  - Even part:
    - g0=u0+C4*u4, g1=u0-C4*u4.
    - h0=C2*u2+C6*u6, h1=C6*u2-C2*u6.
    - E0=g0+h0, E1=g1+h1, E2=g1-h1, E3=g0-h0.
  - Odd part:
    - O0=C1u1+C3u3+S3u5+S1u7
    - O1=C3u1-S1u3-C1u5-S3u7
    - O2=S3u1-C1u3+S1u5+C3u7
    - O3=S1u1-S3u3+C3u5-C1u7
  - Outputs: x[n]=E[n]+O[n]; x[7-n]=E[n]-O[n], n=0..3.
  - Every product passes through a shared multiplier. All adds are IN_W bits, wrap-around (two's complement); no intermediate saturation.
- FSM states:
  - S_IDLE: in_ready=1. On in_valid, capture in0..in7 into registers and go to P0.
  - P0: 8 prescale products -> u0..u7.
  - P1: 5 even products (C4u4, C2u2, C6u6, C6u2, C2u6) produce g0, g1, h0, h1. Also 3 odd products: C1u1, C3u1, S3u1.
  - P2: 8 odd products for u3 and u5 terms. Accumulate partial O0..O3.
  - P3: remaining 5 odd products (S1u1, S1u7, S3u7, C3u7, C1u7). Complete O0..O3 and register all 8 outputs.
  - S_WAIT: out_valid=1. On out_ready go to S_IDLE.
  - Unused multiplier slots are driven with a=0, b=0.
- Latency and throughput:
  - Accept edge T; out_valid rises after edge T+4.
  - Minimum 6 cycles per row; out_valid and in_ready are never high together.
- Handshake rules:
  - in_valid is ignored outside S_IDLE.
  - In S_WAIT, out0..out7 and out_valid are stable until out_ready is sampled high.
  - The output transfer completes on the edge where out_valid && out_ready.
- Reset:
  - Async assert forces state=S_IDLE, in_ready=1, out_valid=0, out0..out7=0, all internal registers 0.
  - Reset in any phase aborts the row with no output.
  - Deassertion is used synchronously.

Optional Feature:
- Macro IDCT8_PIXEL_CLAMP_EN.
- Defined: each output is saturated to [-(128<<FRAC), (127<<FRAC)] when registered in P3. This is the level-shifted 8-bit pixel range.
- Undefined: raw IN_W wrap-around result.
- Timing and handshake are identical in both builds.

Test Plan:
- DC: in0=262144 (8.0), rest 0 -> all out0..out7 = 92680 exactly; out_valid high 4 cycles after the accept edge.
- X4 only: in4=65536 -> out0,out3,out4,out7 = +23170; out1,out2,out5,out6 = -23170.
- X1 only: in1=65536 -> out0..out7 = 32138, 27246, 18205, 6393, -6393, -18205, -27246, -32138.
- Backpressure: out_ready=0 for 10 cycles after out_valid, in_valid held high with new data -> outputs and out_valid stable, in_ready=0, second row accepted only in the cycle after out_ready is sampled high.
- Reset mid-op: drop rst_n during P2 -> immediately out_valid=0, in_ready=1, outputs 0; next row after release produces the correct result.
- Clamp: in0=32768000 (1000.0) -> with IDCT8_PIXEL_CLAMP_EN all outputs 4161536; without it all outputs 11585000.
